// File: rtl/button_conditioner.sv
// ----------------------------------------------------------------------------
// button_conditioner
//
// Conditions four raw push-buttons and sixteen slide switches for use in the
// clk domain. Every raw input first passes through a 2-flop synchronizer.
// Each button then runs its own debounce FSM and counter. A level change is
// accepted only after the synchronized input has held the new value through
// DEBOUNCE_CYCLES counting edges. The switches are synchronized only and are
// not debounced.
//
// Ports
//   clk         in   1   system clock, all state updates on the rising edge
//   rst_n       in   1   synchronous active-low reset
//   btnL/U/R/D  in   1   raw asynchronous bouncing push-buttons
//   sw          in   16  raw asynchronous slide switches
//   btn_level   out  4   debounced levels, {L,U,R,D} = [3:0]
//   btn_rise    out  4   one-cycle pulse per debounced press
//   btn_toggle  out  4   flips on every debounced press
//   sw_sync     out  16  switches after the 2-flop synchronizer
// ----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btnL,
    input  logic        btnU,
    input  logic        btnR,
    input  logic        btnD,
    input  logic [15:0] sw,
    output logic [3:0]  btn_level,
    output logic [3:0]  btn_rise,
    output logic [3:0]  btn_toggle,
    output logic [15:0] sw_sync
);

    // The counter only needs to reach DEBOUNCE_CYCLES-1, and that value
    // always fits in $clog2(DEBOUNCE_CYCLES) bits.
    localparam int             CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [3:0]  btn_raw_s;
    logic [3:0]  btn_meta_r;
    logic [3:0]  btn_sync_r;
    logic [15:0] sw_meta_r;

    assign btn_raw_s = {btnL, btnU, btnR, btnD};

    // Two-flop synchronizers for buttons and switches; the switch
    // synchronizer's second stage is the sw_sync output itself.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_meta_r <= 4'b0000;
            btn_sync_r <= 4'b0000;
            sw_meta_r  <= 16'h0000;
            sw_sync    <= 16'h0000;
        end else begin
            btn_meta_r <= btn_raw_s;
            btn_sync_r <= btn_meta_r;
            sw_meta_r  <= sw;
            sw_sync    <= sw_meta_r;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            state_t        state_r;
            logic [CW-1:0] cnt_r;
            logic          level_r;
            logic          rise_r;
            logic          toggle_r;

            // Per-button debounce FSM. The level, rise and toggle outputs
            // update on the same edge as the accepting transition, so they
            // remain registered without adding a cycle of latency.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_r  <= IDLE_LOW;
                    cnt_r    <= '0;
                    level_r  <= 1'b0;
                    rise_r   <= 1'b0;
                    toggle_r <= 1'b0;
                end else begin
                    rise_r <= 1'b0;
                    case (state_r)
                        IDLE_LOW: begin
                            if (btn_sync_r[gi]) begin
                                state_r <= WAIT_HIGH;
                                cnt_r   <= '0;
                            end
                        end
                        WAIT_HIGH: begin
                            if (!btn_sync_r[gi]) begin
                                state_r <= IDLE_LOW;
                            end else if (cnt_r == CNT_MAX) begin
                                state_r  <= IDLE_HIGH;
                                level_r  <= 1'b1;
                                rise_r   <= 1'b1;
                                toggle_r <= ~toggle_r;
                            end else begin
                                cnt_r <= cnt_r + CNT_ONE;
                            end
                        end
                        IDLE_HIGH: begin
                            if (!btn_sync_r[gi]) begin
                                state_r <= WAIT_LOW;
                                cnt_r   <= '0;
                            end
                        end
                        WAIT_LOW: begin
                            if (btn_sync_r[gi]) begin
                                state_r <= IDLE_HIGH;
                            end else if (cnt_r == CNT_MAX) begin
                                state_r <= IDLE_LOW;
                                level_r <= 1'b0;
                            end else begin
                                cnt_r <= cnt_r + CNT_ONE;
                            end
                        end
                        default: begin
                            // Unreachable encoding: recover to a known released state.
                            state_r <= IDLE_LOW;
                            cnt_r   <= '0;
                            level_r <= 1'b0;
                        end
                    endcase
                end
            end

            assign btn_level[gi]  = level_r;
            assign btn_rise[gi]   = rise_r;
            assign btn_toggle[gi] = toggle_r;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// ----------------------------------------------------------------------------
// tb_button_conditioner
//
// Directed scenarios followed by randomized activity on buttons, switches and
// reset. Every cycle is compared against a reference model. The model tracks
// how many consecutive synchronized samples have disagreed with the current
// debounced level. When that run reaches DEBOUNCE_CYCLES+1, the debounced
// level flips.
// ----------------------------------------------------------------------------
module tb_button_conditioner;

    localparam int DC = 4;

    logic        clk;
    logic        rst_n;
    logic        btnL, btnU, btnR, btnD;
    logic [15:0] sw;
    logic [3:0]  btn_level, btn_rise, btn_toggle;
    logic [15:0] sw_sync;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state
    logic [3:0]  m_d1, m_d2;
    logic [3:0]  m_level, m_rise, m_tog;
    int          m_run [4];
    logic [15:0] m_sw1, m_sw_sync;

    button_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btnL       (btnL),
        .btnU       (btnU),
        .btnR       (btnR),
        .btnD       (btnD),
        .sw         (sw),
        .btn_level  (btn_level),
        .btn_rise   (btn_rise),
        .btn_toggle (btn_toggle),
        .sw_sync    (sw_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %h expected %h", tag, cycle, obs, exp);
        end
    endtask

    // Advance one clock edge, update the model with the inputs seen at that
    // edge, then compare every output.
    task automatic tick();
        logic [3:0] raw;
        @(posedge clk);
        #1;
        raw = {btnL, btnU, btnR, btnD};
        if (!rst_n) begin
            m_d1 = 4'b0000; m_d2 = 4'b0000;
            m_level = 4'b0000; m_rise = 4'b0000; m_tog = 4'b0000;
            m_sw1 = 16'h0000; m_sw_sync = 16'h0000;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                m_rise[i] = 1'b0;
                if (m_d2[i] != m_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DC + 1) begin
                        m_level[i] = m_d2[i];
                        m_run[i]   = 0;
                        if (m_d2[i]) begin
                            m_rise[i] = 1'b1;
                            m_tog[i]  = ~m_tog[i];
                        end
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_d2      = m_d1;
            m_d1      = raw;
            m_sw_sync = m_sw1;
            m_sw1     = sw;
        end
        cycle++;
        chk("model_level",  {12'h000, btn_level},  {12'h000, m_level});
        chk("model_rise",   {12'h000, btn_rise},   {12'h000, m_rise});
        chk("model_toggle", {12'h000, btn_toggle}, {12'h000, m_tog});
        chk("model_sw",     sw_sync,               m_sw_sync);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int n_rise;
        int lat;
        logic [3:0] pat;

        rst_n = 1'b0; btnL = 1'b0; btnU = 1'b0; btnR = 1'b0; btnD = 1'b0; sw = 16'h0000;
        m_d1 = 4'b0000; m_d2 = 4'b0000; m_level = 4'b0000; m_rise = 4'b0000; m_tog = 4'b0000;
        m_sw1 = 16'h0000; m_sw_sync = 16'h0000;
        for (int i = 0; i < 4; i++) m_run[i] = 0;

        // Reset state
        sw = 16'hFFFF; btnU = 1'b1;
        ticks(3);
        chk("reset_level",  {12'h000, btn_level},  16'h0000);
        chk("reset_rise",   {12'h000, btn_rise},   16'h0000);
        chk("reset_toggle", {12'h000, btn_toggle}, 16'h0000);
        chk("reset_sw",     sw_sync,               16'h0000);
        btnU = 1'b0; sw = 16'h0000;

        // btnL held from edge 1 after reset: accepted on edge 7
        rst_n = 1'b1; btnL = 1'b1;
        ticks(6);
        chk("L_before7", {12'h000, btn_level}, 16'h0000);
        tick();
        chk("L_level7",  {12'h000, btn_level},  16'h0008);
        chk("L_rise7",   {12'h000, btn_rise},   16'h0008);
        chk("L_toggle7", {12'h000, btn_toggle}, 16'h0008);
        tick();
        chk("L_rise8",   {12'h000, btn_rise},   16'h0000);
        btnL = 1'b0;
        ticks(12);

        // btnR press, release (no rise pulse), second press returns toggle[1] to 0
        btnR = 1'b1;
        ticks(10);
        btnR = 1'b0;
        ticks(6);
        chk("R_still_high", {15'h0000, btn_level[1]}, 16'h0001);
        tick();
        chk("R_fell",     {15'h0000, btn_level[1]}, 16'h0000);
        chk("R_no_rise",  {12'h000, btn_rise},      16'h0000);
        chk("R_tog_mid",  {15'h0000, btn_toggle[1]}, 16'h0001);
        btnR = 1'b1;
        ticks(7);
        chk("R_tog_back", {15'h0000, btn_toggle[1]}, 16'h0000);
        btnR = 1'b0;
        ticks(12);

        // btnU bounce 1,0,1,0 (2 cycles each) then settle at 1
        n_rise = 0;
        pat = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            btnU = pat[k];
            tick(); if (btn_rise[2]) n_rise++;
            tick(); if (btn_rise[2]) n_rise++;
        end
        btnU = 1'b1;
        lat = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (btn_rise[2]) n_rise++;
            if (lat == 0 && btn_level[2]) lat = k;
        end
        chk("U_latency", lat[15:0],    16'd7);
        chk("U_rises",   n_rise[15:0], 16'd1);
        btnU = 1'b0;
        ticks(12);

        // btnL and btnD pressed on the same edge
        btnL = 1'b1; btnD = 1'b1;
        ticks(7);
        chk("LD_rise",  {12'h000, btn_rise}, 16'h0009);
        tick();
        chk("LD_rise2", {12'h000, btn_rise}, 16'h0000);
        btnL = 1'b0; btnD = 1'b0;
        ticks(12);

        // Reset during WAIT_HIGH with cnt=2, button still held afterwards
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        btnL = 1'b1;
        ticks(5);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_level",  {12'h000, btn_level},  16'h0000);
        chk("rst_mid_rise",   {12'h000, btn_rise},   16'h0000);
        chk("rst_mid_toggle", {12'h000, btn_toggle}, 16'h0000);
        rst_n = 1'b1;
        ticks(6);
        chk("rst_rel_before", {12'h000, btn_level}, 16'h0000);
        chk("rst_rel_norise", {12'h000, btn_rise},  16'h0000);
        tick();
        chk("rst_rel_level", {12'h000, btn_level}, 16'h0008);
        chk("rst_rel_rise",  {12'h000, btn_rise},  16'h0008);
        btnL = 1'b0;
        ticks(12);

        // Switch synchronizer with concurrent button activity
        sw = 16'hA5C3; btnU = 1'b1;
        tick();
        chk("sw_k",  sw_sync, 16'h0000);
        btnU = 1'b0;
        tick();
        chk("sw_k1", sw_sync, 16'hA5C3);
        ticks(4);

        // Randomized activity, checked every cycle against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 5) == 0) btnL = ~btnL;
            if ($urandom_range(0, 5) == 0) btnU = ~btnU;
            if ($urandom_range(0, 5) == 0) btnR = ~btnR;
            if ($urandom_range(0, 5) == 0) btnD = ~btnD;
            if ($urandom_range(0, 9) == 0) sw = 16'($urandom);
            rst_n = ($urandom_range(0, 399) != 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
